// File: rtl/paddle_motion_ctrl.sv
// Per-player paddle position controller with velocity ramp, exact limit saturation and status flags.
// Optional auto-tracking of the ball is enabled by defining PADDLE_AUTO_EN.
module paddle_motion_ctrl #(
    parameter int COORD_W     = 10,
    parameter int HEIGHT_W    = 8,
    parameter int VEL_W       = 4,
    parameter int OFFSET      = 5,
    parameter int RESET_Y     = 200,
    parameter int PLAYER      = 0,
    parameter int X_LEFT      = 20,
    parameter int X_RIGHT     = 600,
    parameter int ACCEL_TICKS = 4
) (
    input  logic                game_clk,
    input  logic                reset,
    input  logic                move_en,
    input  logic                input_up,
    input  logic                input_down,
    input  logic [COORD_W-1:0]  y_ceil,
    input  logic [COORD_W-1:0]  y_floor,
    input  logic [HEIGHT_W-1:0] height_paddle,
    input  logic [VEL_W-1:0]    vel_base,
    input  logic [VEL_W-1:0]    vel_max,
    input  logic                auto_mode,
    input  logic [COORD_W-1:0]  ball_y,
    output logic [COORD_W-1:0]  paddle_y,
    output logic [COORD_W-1:0]  paddle_x,
    output logic [VEL_W-1:0]    vel_cur,
    output logic                at_ceil,
    output logic                at_floor
);

    localparam int W      = COORD_W + 2;
    localparam int HOLD_W = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(ACCEL_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_ENTRY = (ACCEL_TICKS == 1) ? '0 : HOLD_W'(1);
    localparam logic [W-1:0]      Y_MAX      = W'((1 << COORD_W) - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_UP, ST_DOWN} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

    function automatic logic [W-1:0] clamp_range(input logic [W-1:0] v,
                                                 input logic [W-1:0] lo,
                                                 input logic [W-1:0] hi);
        if (v < lo)
            return lo;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    function automatic logic [COORD_W-1:0] sat_coord(input logic [W-1:0] v);
        return (v > Y_MAX) ? '1 : v[COORD_W-1:0];
    endfunction

    function automatic logic [VEL_W-1:0] sat_vel(input logic [VEL_W:0] v,
                                                 input logic [VEL_W-1:0] vmax);
        return (v > {1'b0, vmax}) ? vmax : v[VEL_W-1:0];
    endfunction

    state_t              state, state_nxt;
    dir_t                dir, manual_dir, move_dir;
    logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
    logic [VEL_W-1:0]    boost, boost_nxt;
    logic [VEL_W-1:0]    vel_entry, step;
    logic [VEL_W:0]      vel_sum;
    logic                ramp_room, held, toggle;
    logic [W-1:0]        top_lim, bot_raw, bot_lim, margin;
    logic [W-1:0]        y_wide, y_moved, y_clamped;
    logic [COORD_W-1:0]  y_nxt;
    logic                ceil_nxt, floor_nxt;

    assign paddle_x = (PLAYER == 1) ? COORD_W'(X_LEFT) : COORD_W'(X_RIGHT);

    // Limits at COORD_W+2 bits; bottom floors at 0 and collapses onto top in a degenerate field
    assign top_lim = W'(y_ceil) + W'(OFFSET);
    assign margin  = W'(OFFSET) + W'(height_paddle);
    assign bot_raw = (W'(y_floor) > margin) ? W'(y_floor) - margin : '0;
    assign bot_lim = (bot_raw < top_lim) ? top_lim : bot_raw;

    // vel_cur is held as a ramp offset over vel_base so that async reset restores vel_base directly
    assign vel_sum   = {1'b0, vel_base} + {1'b0, boost};
    assign vel_cur   = sat_vel(vel_sum, vel_max);
    assign vel_entry = sat_vel({1'b0, vel_base}, vel_max);
    assign ramp_room = vel_sum < {1'b0, vel_max};

    always_comb begin
        manual_dir = DIR_NONE;
        if (input_up && !input_down)
            manual_dir = DIR_UP;
        else if (input_down && !input_up)
            manual_dir = DIR_DOWN;
    end

`ifdef PADDLE_AUTO_EN
    logic         auto_q;
    logic [W-1:0] center;
    dir_t         auto_dir;

    assign center = W'(paddle_y) + W'(height_paddle >> 1);

    always_comb begin
        auto_dir = DIR_NONE;
        if (W'(ball_y) + W'(2) < center)
            auto_dir = DIR_UP;
        else if (W'(ball_y) > center + W'(2))
            auto_dir = DIR_DOWN;
    end

    assign dir    = auto_mode ? auto_dir : manual_dir;
    assign toggle = auto_mode ^ auto_q;

    always_ff @(posedge game_clk or posedge reset) begin
        if (reset)
            auto_q <= 1'b0;
        else if (move_en)
            auto_q <= auto_mode;
    end
`else
    logic unused_auto;
    assign unused_auto = ^{auto_mode, ball_y};
    assign dir         = manual_dir;
    assign toggle      = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        boost_nxt = boost;
        move_dir  = DIR_NONE;
        step      = vel_cur;
        held      = 1'b0;
        case (state)
            ST_UP:   held = (dir == DIR_UP);
            ST_DOWN: held = (dir == DIR_DOWN);
            default: held = 1'b0;
        endcase
        if (toggle || dir == DIR_NONE) begin
            state_nxt = ST_IDLE;
            hold_nxt  = '0;
            boost_nxt = '0;
        end else begin
            move_dir  = dir;
            state_nxt = (dir == DIR_UP) ? ST_UP : ST_DOWN;
            if (held) begin
                if (hold_cnt == HOLD_LAST) begin
                    hold_nxt = '0;
                    if (ramp_room)
                        boost_nxt = boost + VEL_W'(1);
                end else begin
                    hold_nxt = hold_cnt + HOLD_W'(1);
                end
            end else begin
                // Fresh press or reversal: the entry tick itself counts as the first held tick
                step      = vel_entry;
                hold_nxt  = HOLD_ENTRY;
                boost_nxt = '0;
                if (ACCEL_TICKS == 1 && vel_entry < vel_max)
                    boost_nxt = VEL_W'(1);
            end
        end
    end

    always_comb begin
        y_wide  = W'(paddle_y);
        y_moved = y_wide;
        case (move_dir)
            DIR_UP:   y_moved = (y_wide > W'(step)) ? y_wide - W'(step) : '0;
            DIR_DOWN: y_moved = y_wide + W'(step);
            default:  y_moved = y_wide;
        endcase
        // Clamping unconditionally also pulls an out-of-range paddle back into the field
        y_clamped = clamp_range(y_moved, top_lim, bot_lim);
        y_nxt     = sat_coord(y_clamped);
        ceil_nxt  = (W'(y_nxt) == top_lim);
        floor_nxt = (W'(y_nxt) == bot_lim);
    end

    always_ff @(posedge game_clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            hold_cnt <= '0;
            boost    <= '0;
            paddle_y <= COORD_W'(RESET_Y);
            at_ceil  <= 1'b0;
            at_floor <= 1'b0;
        end else if (move_en) begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            boost    <= boost_nxt;
            paddle_y <= y_nxt;
            at_ceil  <= ceil_nxt;
            at_floor <= floor_nxt;
        end
    end

endmodule
